// File: rtl/ram_pkg.sv
// Shared widths and types for the burst RAM port and its arbiter.
package ram_pkg;

    localparam int AWIDTH = 32;
    localparam int LWIDTH = 8;
    localparam int DWIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module arb_rr2
    import ram_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     gnt
);

    always_comb begin
        gnt = OWN_I;
        if (req[0] && req[1]) begin
            gnt = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (req[1]) begin
            gnt = OWN_D;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one burst RAM port between icache and dcache, one whole transaction per grant.
module ram_arbiter #(
    parameter int AWIDTH = ram_pkg::AWIDTH,
    parameter int LWIDTH = ram_pkg::LWIDTH,
    parameter int DWIDTH = ram_pkg::DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    // icache side
    input  logic [AWIDTH-1:0] i_ram_awaddr,
    input  logic [LWIDTH-1:0] i_ram_awlen,
    input  logic              i_ram_awvalid,
    output logic              i_ram_awready,
    input  logic [DWIDTH-1:0] i_ram_wdata,
    input  logic              i_ram_wready,
    output logic              i_ram_wvalid,
    output logic              i_ram_wlast,
    input  logic [AWIDTH-1:0] i_ram_araddr,
    input  logic [LWIDTH-1:0] i_ram_arlen,
    input  logic              i_ram_arvalid,
    output logic              i_ram_arready,
    output logic [DWIDTH-1:0] i_ram_rdata,
    output logic              i_ram_rvalid,
    output logic              i_ram_rlast,
    input  logic              i_ram_rready,
    // dcache side
    input  logic [AWIDTH-1:0] d_ram_awaddr,
    input  logic [LWIDTH-1:0] d_ram_awlen,
    input  logic              d_ram_awvalid,
    output logic              d_ram_awready,
    input  logic [DWIDTH-1:0] d_ram_wdata,
    input  logic              d_ram_wready,
    output logic              d_ram_wvalid,
    output logic              d_ram_wlast,
    input  logic [AWIDTH-1:0] d_ram_araddr,
    input  logic [LWIDTH-1:0] d_ram_arlen,
    input  logic              d_ram_arvalid,
    output logic              d_ram_arready,
    output logic [DWIDTH-1:0] d_ram_rdata,
    output logic              d_ram_rvalid,
    output logic              d_ram_rlast,
    input  logic              d_ram_rready,
    // RAM side
    output logic [AWIDTH-1:0] ram_awaddr,
    output logic [LWIDTH-1:0] ram_awlen,
    output logic              ram_awvalid,
    input  logic              ram_awready,
    output logic [DWIDTH-1:0] ram_wdata,
    output logic              ram_wready,
    input  logic              ram_wvalid,
    input  logic              ram_wlast,
    output logic [AWIDTH-1:0] ram_araddr,
    output logic [LWIDTH-1:0] ram_arlen,
    output logic              ram_arvalid,
    input  logic              ram_arready,
    input  logic [DWIDTH-1:0] ram_rdata,
    input  logic              ram_rvalid,
    input  logic              ram_rlast,
    output logic              ram_rready
);

    import ram_pkg::*;

    arb_state_t r_state;
    owner_t     r_owner;
    owner_t     r_last;
    owner_t     w_gnt;
    logic [1:0] w_req;
    logic       w_own_d;
    logic       w_raddr;
    logic       w_rdata;
    logic       w_waddr;
    logic       w_wdata;
    logic       w_unused;

    // The icache never writes, so its write-side inputs go nowhere.
    assign w_unused = ^{i_ram_awaddr, i_ram_awlen, i_ram_awvalid, i_ram_wdata, i_ram_wready};

    assign w_req = {d_ram_awvalid | d_ram_arvalid, i_ram_arvalid};

    arb_rr2 u_rr (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_I;
            r_last  <= OWN_D;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_gnt;
                        r_last  <= w_gnt;
                        r_state <= (w_gnt == OWN_D && d_ram_awvalid) ? ST_WADDR : ST_RADDR;
                    end
                end
                ST_RADDR: if (ram_arvalid && ram_arready) r_state <= ST_RDATA;
                ST_RDATA: if (ram_rvalid && ram_rready && ram_rlast) r_state <= ST_IDLE;
                ST_WADDR: if (ram_awvalid && ram_awready) r_state <= ST_WDATA;
                ST_WDATA: if (ram_wvalid && ram_wready && ram_wlast) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_own_d = (r_owner == OWN_D);
    assign w_raddr = (r_state == ST_RADDR);
    assign w_rdata = (r_state == ST_RDATA);
    // Write states are only ever entered on a dcache grant.
    assign w_waddr = (r_state == ST_WADDR);
    assign w_wdata = (r_state == ST_WDATA);

    assign ram_araddr  = w_raddr ? (w_own_d ? d_ram_araddr  : i_ram_araddr)  : '0;
    assign ram_arlen   = w_raddr ? (w_own_d ? d_ram_arlen   : i_ram_arlen)   : '0;
    assign ram_arvalid = w_raddr & (w_own_d ? d_ram_arvalid : i_ram_arvalid);
    assign ram_rready  = w_rdata & (w_own_d ? d_ram_rready  : i_ram_rready);

    assign ram_awaddr  = w_waddr ? d_ram_awaddr : '0;
    assign ram_awlen   = w_waddr ? d_ram_awlen  : '0;
    assign ram_awvalid = w_waddr & d_ram_awvalid;
    assign ram_wdata   = w_wdata ? d_ram_wdata  : '0;
    assign ram_wready  = w_wdata & d_ram_wready;

    assign i_ram_arready = w_raddr & ~w_own_d & ram_arready;
    assign i_ram_rdata   = (w_rdata & ~w_own_d) ? ram_rdata : '0;
    assign i_ram_rvalid  = w_rdata & ~w_own_d & ram_rvalid;
    assign i_ram_rlast   = w_rdata & ~w_own_d & ram_rlast;
    assign i_ram_awready = 1'b0;
    assign i_ram_wvalid  = 1'b0;
    assign i_ram_wlast   = 1'b0;

    assign d_ram_arready = w_raddr & w_own_d & ram_arready;
    assign d_ram_rdata   = (w_rdata & w_own_d) ? ram_rdata : '0;
    assign d_ram_rvalid  = w_rdata & w_own_d & ram_rvalid;
    assign d_ram_rlast   = w_rdata & w_own_d & ram_rlast;
    assign d_ram_awready = w_waddr & ram_awready;
    assign d_ram_wvalid  = w_wdata & ram_wvalid;
    assign d_ram_wlast   = w_wdata & ram_wlast;

endmodule
